// File: rtl/tt_seq_pkg.sv
// Shared types and constants for the times-table sequencer.
package tt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } tt_state_t;

  localparam int TT_DEF_WIDTH        = 3;
  localparam int TT_DEF_MULT_LATENCY = 1;

  // Rows in one table: every value the operand width can express.
  function automatic int tt_rows(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/tt_row_buffer.sv
// Row buffer: one registered write port (product capture) and one
// asynchronous read port (output pointer). Cleared on reset.
module tt_row_buffer
  import tt_seq_pkg::*;
#(
  parameter int WIDTH = TT_DEF_WIDTH,
  parameter int ROWS  = tt_rows(TT_DEF_WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [WIDTH-1:0]   waddr,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]   raddr,
  output logic [2*WIDTH-1:0] rdata
);

  logic [ROWS-1:0][2*WIDTH-1:0] mem;

  // Capture write; reset leaves no stale rows from an abandoned table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/times_table_sequencer.sv
// Times-table sequencer: issues (0..ROWS-1) x table to an external
// multiplier, captures the products after MULT_LATENCY cycles into a row
// buffer and streams the finished table over valid/ready.
// Optional: define TT_SEQ_CHECK_EN to cross-check every captured product
// against a local multiply and raise a sticky err on mismatch.
module times_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int WIDTH        = TT_DEF_WIDTH,
  parameter int MULT_LATENCY = TT_DEF_MULT_LATENCY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   table_sel,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_enable,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [WIDTH-1:0]   row_index,
  output logic [2*WIDTH-1:0] row_product,
  output logic               err
);

  localparam int             ROWS = tt_rows(WIDTH);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(ROWS - 1);

  tt_state_t                              state;
  logic [WIDTH-1:0]                       tbl;
  logic [WIDTH-1:0]                       ptr;
  logic [MULT_LATENCY-1:0]                vld_pipe;
  logic [MULT_LATENCY-1:0][WIDTH-1:0]     idx_pipe;
  logic                                   cap_en;
  logic [WIDTH-1:0]                       cap_idx;
  logic [2*WIDTH-1:0]                     rd_prod;

  assign cap_en  = vld_pipe[MULT_LATENCY-1];
  assign cap_idx = idx_pipe[MULT_LATENCY-1];

  // Tag pipe mirrors the multiplier latency so each product lands on its row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= mul_enable;
      idx_pipe[0] <= mul_a;
      for (int i = MULT_LATENCY - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // Control FSM: all outputs registered; done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      tbl        <= '0;
      mul_a      <= '0;
      mul_enable <= 1'b0;
      row_valid  <= 1'b0;
      ptr        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tbl        <= table_sel;
          mul_a      <= '0;
          mul_enable <= 1'b1;
          busy       <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: if (mul_a == LAST) begin
          mul_a      <= '0;
          mul_enable <= 1'b0;
          state      <= DRAIN;
        end else begin
          mul_a <= mul_a + 1'b1;
        end
        // Last tag was pushed on DRAIN entry, so the pipe is non-empty until
        // the final capture has been written.
        DRAIN: if (!(|vld_pipe)) begin
          ptr       <= '0;
          row_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: if (row_ready) begin
          if (ptr == LAST) begin
            ptr       <= '0;
            row_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tt_row_buffer #(.WIDTH(WIDTH), .ROWS(ROWS)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cap_en),
    .waddr (cap_idx),
    .wdata (mul_result),
    .raddr (ptr),
    .rdata (rd_prod)
  );

  assign mul_b       = tbl;
  assign row_index   = ptr;
  assign row_product = row_valid ? rd_prod : '0;

`ifdef TT_SEQ_CHECK_EN
  logic [2*WIDTH-1:0] ref_prod;
  assign ref_prod = {{WIDTH{1'b0}}, cap_idx} * {{WIDTH{1'b0}}, tbl};

  // Sticky checker; a new accepted start begins a fresh table with err clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (state == IDLE && start) err <= 1'b0;
    else if (cap_en && mul_result != ref_prod) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
